// File: rtl/countdown_entry_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_entry_ctrl
//
// Purpose:
//    Turns decoded keypad strobes into an mm:ss countdown. Up to four BCD
//    digits are accumulated. Confirm validates them. The timer is then armed,
//    and start runs a BCD down-counter that decrements once every TICK_DIV
//    clock cycles until it reaches 00:00.
//
// Parameters:
//    TICK_DIV  clk cycles per countdown second (>= 2)
//    TICK_W    prescaler width, 2**TICK_W >= TICK_DIV
//
// Ports:
//    clk              system clock (shared with the keypad stage)
//    rst              asynchronous reset, active-high
//    keydown_start    one-cycle strobe, start key
//    keydown_confirm  one-cycle strobe, confirm key
//    keydown_clear    one-cycle strobe, clear key
//    keydown_num      one-cycle strobe, numeric key (value on num)
//    num[3:0]         key value, only 0..9 are accepted
//    digits[15:0]     BCD {m_tens, m_ones, s_tens, s_ones}
//    state[2:0]       IDLE=000 ENTRY=001 ARMED=010 RUN=011 DONE=100 PAUSE=101
//    running          high in RUN
//    done             high in DONE
//    err              one-cycle pulse on a rejected confirm
//
// Build option:
//    COUNTDOWN_PAUSE_EN  when defined, start toggles RUN <-> PAUSE. When it
//                        is undefined, start in RUN is ignored and code 101
//                        decodes back to IDLE.
//
// All outputs are registered and reflect a strobe on the cycle after it.
// -----------------------------------------------------------------------------
module countdown_entry_ctrl #(
   parameter int TICK_DIV = 1000,
   parameter int TICK_W   = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        keydown_start,
   input  logic        keydown_confirm,
   input  logic        keydown_clear,
   input  logic        keydown_num,
   input  logic [3:0]  num,
   output logic [15:0] digits,
   output logic [2:0]  state,
   output logic        running,
   output logic        done,
   output logic        err
);

   // ---------------------------------------------------------------------
   // Types and constants
   // ---------------------------------------------------------------------
   typedef enum logic [2:0] {
      ST_IDLE  = 3'b000,
      ST_ENTRY = 3'b001,
      ST_ARMED = 3'b010,
      ST_RUN   = 3'b011,
      ST_DONE  = 3'b100,
      ST_PAUSE = 3'b101
   } state_e;

   // The single key acted on in a cycle once strobe priority is resolved.
   typedef enum logic [2:0] {
      KEY_NONE,
      KEY_NUM,
      KEY_START,
      KEY_CONFIRM,
      KEY_CLEAR
   } key_e;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [2:0]        MAX_DIGITS = 3'd4;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_e            state_q,   state_d;
   logic [15:0]       digits_q,  digits_d;
   logic [2:0]        count_q,   count_d;
   logic [TICK_W-1:0] presc_q,   presc_d;
   logic              err_q,     err_d;
   logic              running_q, running_d;
   logic              done_q,    done_d;

   // ---------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------

   // mm:ss decrement in BCD. Seconds borrow through 59, minutes through 99.
   // The caller never passes 00:00.
   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      logic [3:0] m_tens, m_ones, s_tens, s_ones;
      {m_tens, m_ones, s_tens, s_ones} = v;
      if (s_ones != 4'd0) begin
         s_ones = s_ones - 4'd1;
      end else begin
         s_ones = 4'd9;
         if (s_tens != 4'd0) begin
            s_tens = s_tens - 4'd1;
         end else begin
            s_tens = 4'd5;
            if (m_ones != 4'd0) begin
               m_ones = m_ones - 4'd1;
            end else begin
               m_ones = 4'd9;
               m_tens = m_tens - 4'd1;
            end
         end
      end
      return {m_tens, m_ones, s_tens, s_ones};
   endfunction

   key_e        key;
   logic        num_valid;
   logic        entry_ok;
   logic        tick;
   logic [15:0] dec_val;

   assign num_valid = (num <= 4'd9);
   // An entry is accepted when its seconds-tens digit is 0..5 and it is not
   // all zeros. m_tens is unrestricted, so the limit is 99:59.
   assign entry_ok  = (digits_q[7:4] <= 4'd5) && (digits_q != 16'h0000);
   assign tick      = (presc_q == TICK_LAST);
   assign dec_val   = bcd_dec(digits_q);

   // Strobe priority is clear > confirm > start > num. Only the winner is
   // handled, even if the current state ignores it. An out-of-range num is
   // never a candidate.
   always_comb begin
      key = KEY_NONE;
      if (keydown_clear) begin
         key = KEY_CLEAR;
      end else if (keydown_confirm) begin
         key = KEY_CONFIRM;
      end else if (keydown_start) begin
         key = KEY_START;
      end else if (keydown_num && num_valid) begin
         key = KEY_NUM;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------
   // NOTE: every signal this block drives gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      digits_d = digits_q;
      count_d = count_q;
      presc_d = presc_q;
      err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (key == KEY_NUM) begin
               digits_d = {12'h000, num};
               count_d = 3'd1;
               state_d = ST_ENTRY;
            end
         end

         ST_ENTRY: begin
            case (key)
               KEY_CLEAR: begin
                  digits_d = 16'h0000;
                  count_d = 3'd0;
                  state_d = ST_IDLE;
               end
               KEY_CONFIRM: begin
                  if (entry_ok) begin
                     state_d = ST_ARMED;
                  end else begin
                     err_d = 1'b1;
                     digits_d = 16'h0000;
                     count_d = 3'd0;
                     state_d = ST_IDLE;
                  end
               end
               KEY_NUM: begin
                  // A fifth digit is dropped and the existing four are kept.
                  if (count_q < MAX_DIGITS) begin
                     digits_d = {digits_q[11:0], num};
                     count_d = count_q + 3'd1;
                  end
               end
               default: ;
            endcase
         end

         ST_ARMED: begin
            if (key == KEY_CLEAR) begin
               digits_d = 16'h0000;
               count_d = 3'd0;
               state_d = ST_IDLE;
            end else if (key == KEY_START) begin
               // The prescaler restarts here, so the first decrement lands
               // exactly TICK_DIV cycles after the start strobe.
               presc_d = '0;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            // Clear aborts and takes precedence over a coincident tick.
            if (key == KEY_CLEAR) begin
               digits_d = 16'h0000;
               count_d = 3'd0;
               presc_d = '0;
               state_d = ST_IDLE;
`ifdef COUNTDOWN_PAUSE_EN
            end else if (key == KEY_START) begin
               // The prescaler and the digits hold their values while paused.
               state_d = ST_PAUSE;
`endif
            end else if (tick) begin
               presc_d = '0;
               if (dec_val == 16'h0000) begin
                  digits_d = 16'h0000;
                  state_d = ST_DONE;
               end else begin
                  digits_d = dec_val;
               end
            end else begin
               presc_d = presc_q + TICK_W'(1);
            end
         end

         ST_DONE: begin
            digits_d = 16'h0000;
            if ((key == KEY_CLEAR) || (key == KEY_CONFIRM)) begin
               count_d = 3'd0;
               state_d = ST_IDLE;
            end
         end

`ifdef COUNTDOWN_PAUSE_EN
         ST_PAUSE: begin
            if (key == KEY_CLEAR) begin
               digits_d = 16'h0000;
               count_d = 3'd0;
               presc_d = '0;
               state_d = ST_IDLE;
            end else if (key == KEY_START) begin
               state_d = ST_RUN;
            end
         end
`endif

         // Unused codes, including PAUSE when the pause option is not built,
         // fall back to a clean IDLE.
         default: begin
            digits_d = 16'h0000;
            count_d = 3'd0;
            presc_d = '0;
            state_d = ST_IDLE;
         end
      endcase

      running_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments. All registers
   // therefore update together from values sampled before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         digits_q <= 16'h0000;
         count_q <= 3'd0;
         presc_q <= '0;
         err_q <= 1'b0;
         running_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         digits_q <= digits_d;
         count_q <= count_d;
         presc_q <= presc_d;
         err_q <= err_d;
         running_q <= running_d;
         done_q <= done_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign digits = digits_q;
   assign state = state_q;
   assign running = running_q;
   assign done = done_q;
   assign err = err_q;

endmodule

// File: tb/tb_countdown_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_countdown_entry_ctrl
//
// Self-checking bench for countdown_entry_ctrl in its default build, with the
// pause option not defined. The driver issues one set of strobes per cycle at
// the falling edge. It advances a behavioural model that keeps the entered
// digits as a list and the remaining time as a plain count of seconds. The
// driver pushes the expected registered outputs into a queue. A separate
// monitor pops one entry after every rising edge and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_countdown_entry_ctrl;

   localparam int TD = 4;

   localparam int M_IDLE  = 0;
   localparam int M_ENTRY = 1;
   localparam int M_ARMED = 2;
   localparam int M_RUN   = 3;
   localparam int M_DONE  = 4;

   typedef logic [21:0] obs_t;   // {state, digits, running, done, err}

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        k_start = 1'b0;
   logic        k_confirm = 1'b0;
   logic        k_clear = 1'b0;
   logic        k_num = 1'b0;
   logic [3:0]  num = 4'd0;
   logic [15:0] digits;
   logic [2:0]  state;
   logic        running;
   logic        done;
   logic        err;
   obs_t        act;

   int chk_cnt = 0;
   int pass_cnt = 0;
   obs_t exp_q[$];

   // Model state
   int m_mode = M_IDLE;
   int m_ent[$];
   int m_total = 0;
   int m_pcnt = 0;

   always #5 clk = ~clk;

   countdown_entry_ctrl #(
      .TICK_DIV(TD),
      .TICK_W  (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .keydown_start  (k_start),
      .keydown_confirm(k_confirm),
      .keydown_clear  (k_clear),
      .keydown_num    (k_num),
      .num            (num),
      .digits         (digits),
      .state          (state),
      .running        (running),
      .done           (done),
      .err            (err)
   );

   assign act = {state, digits, running, done, err};

   task automatic check(input string name, input obs_t got, input obs_t exp);
      chk_cnt++;
      if (got === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s #%0d: got state=%0d digits=%h run=%0b done=%0b err=%0b, expected state=%0d digits=%h run=%0b done=%0b err=%0b",
                  name, chk_cnt, got[21:19], got[18:3], got[2], got[1], got[0],
                  exp[21:19], exp[18:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Remaining seconds shown as mm:ss in BCD.
   function automatic logic [15:0] to_bcd(input int t);
      int m;
      int s;
      m = t / 60;
      s = t % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic obs_t model_obs(input bit e);
      logic [15:0] d;
      d = 16'h0000;
      if (m_mode == M_ENTRY) begin
         foreach (m_ent[i]) d = {d[11:0], 4'(m_ent[i])};
      end else if (m_mode != M_IDLE) begin
         d = to_bcd(m_total);
      end
      return {3'(m_mode), d, (m_mode == M_RUN), (m_mode == M_DONE), e};
   endfunction

   // One clock of the reference behaviour. It pushes the outputs expected
   // after the coming edge.
   task automatic model_step(input bit s, input bit c, input bit cl,
                             input bit n, input int v);
      int key;   // 4 clear, 3 confirm, 2 start, 1 num, 0 none
      int val;
      bit e;
      e = 1'b0;
      if (cl) key = 4;
      else if (c) key = 3;
      else if (s) key = 2;
      else if (n && v <= 9) key = 1;
      else key = 0;

      case (m_mode)
         M_IDLE: if (key == 1) begin
            m_ent.delete();
            m_ent.push_back(v);
            m_mode = M_ENTRY;
         end
         M_ENTRY: begin
            if (key == 4) begin
               m_ent.delete();
               m_mode = M_IDLE;
            end else if (key == 3) begin
               val = 0;
               foreach (m_ent[i]) val = val * 10 + m_ent[i];   // mmss as decimal
               if ((val % 100) / 10 <= 5 && val != 0) begin
                  m_total = (val / 100) * 60 + (val % 100);
                  m_mode = M_ARMED;
               end else begin
                  e = 1'b1;
                  m_ent.delete();
                  m_mode = M_IDLE;
               end
            end else if (key == 1 && m_ent.size() < 4) begin
               m_ent.push_back(v);
            end
         end
         M_ARMED: begin
            if (key == 4) begin
               m_mode = M_IDLE;
            end else if (key == 2) begin
               m_pcnt = 0;
               m_mode = M_RUN;
            end
         end
         M_RUN: begin
            if (key == 4) begin
               m_mode = M_IDLE;
            end else begin
               m_pcnt++;
               if (m_pcnt == TD) begin
                  m_pcnt = 0;
                  m_total--;
                  if (m_total == 0) m_mode = M_DONE;
               end
            end
         end
         M_DONE: if (key == 4 || key == 3) m_mode = M_IDLE;
         default: m_mode = M_IDLE;
      endcase
      exp_q.push_back(model_obs(e));
   endtask

   // ---------------------------------------------------------------------
   // Driver helpers: each call is exactly one clock cycle
   // ---------------------------------------------------------------------
   task automatic cyc(input bit s, input bit c, input bit cl, input bit n,
                      input logic [3:0] v);
      @(negedge clk);
      k_start = s;
      k_confirm = c;
      k_clear = cl;
      k_num = n;
      num = v;
      model_step(s, c, cl, n, int'(v));
   endtask

   task automatic key_num(input logic [3:0] v); cyc(0, 0, 0, 1, v); endtask
   task automatic key_start();   cyc(1, 0, 0, 0, 4'd0); endtask
   task automatic key_confirm(); cyc(0, 1, 0, 0, 4'd0); endtask
   task automatic key_clear();   cyc(0, 0, 1, 0, 4'd0); endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 4'd0);
   endtask

   task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
      key_num(a); key_num(b); key_num(c); key_num(d);
   endtask

   // Reset asserted between edges. The outputs must clear at once, without
   // waiting for a clock.
   task automatic async_reset();
      @(negedge clk);
      rst = 1'b1;
      k_start = 1'b0; k_confirm = 1'b0; k_clear = 1'b0; k_num = 1'b0; num = 4'd0;
      #1;
      check("async_reset", act, '0);
      m_mode = M_IDLE;
      m_ent.delete();
      m_total = 0;
      m_pcnt = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------
   always begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("cycle", act, exp_q.pop_front());
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      repeat (2) @(negedge clk);
      check("reset_state", act, '0);
      rst = 1'b0;

      // 1:30 countdown to DONE. The first decrement comes TD cycles after start.
      key_num(1); key_num(3); key_num(0); key_confirm();
      key_num(7); key_confirm();            // ignored while armed
      key_start();
      idle(90 * TD + 3);
      key_start(); key_num(2);              // ignored in DONE
      key_confirm();                        // DONE -> IDLE

      // Rejected entries: seconds-tens of 7, then all zeros.
      enter4(0, 1, 7, 5); key_confirm(); idle(2);
      enter4(0, 0, 0, 0); key_confirm(); idle(2);

      // A fifth digit, a non-decimal key and a start in ENTRY are dropped.
      enter4(1, 2, 3, 4); key_num(5); key_num(4'hB); key_start(); key_clear();
      key_num(4'hC); key_confirm(); idle(1);   // ignored in IDLE

      // Minute borrow 10:00 -> 09:59 -> 09:58.
      enter4(1, 0, 0, 0); key_confirm(); key_start(); idle(2 * TD + 1); key_clear();

      // Clear on the same edge as a tick.
      enter4(0, 0, 3, 0); key_confirm(); key_start(); idle(TD - 1); key_clear(); idle(2);

      // Armed then cleared.
      key_num(4'd5); key_confirm(); key_clear(); idle(1);

      // Reset in the middle of a run. No tick may follow it.
      key_num(1); key_num(0); key_num(0); key_confirm(); key_start(); idle(6);
      async_reset();
      idle(3 * TD);

      // Start while running is ignored in this build.
      enter4(0, 0, 1, 0); key_confirm(); key_start(); idle(2);
      key_start(); idle(20); key_start(); idle(12 * TD);
      key_clear();

      // Short countdowns with noise strobes, always finishing in DONE.
      for (int r = 0; r < 6; r++) begin
         key_num(4'($urandom_range(1, 9))); key_confirm(); key_start();
         for (int i = 0; i < 12 * TD; i++) begin
            bit s, c, n;
            s = ($urandom_range(0, 99) < 10);
            c = ($urandom_range(0, 99) < 10);
            n = ($urandom_range(0, 99) < 15);
            cyc(s, c, 1'b0, n, 4'($urandom_range(0, 15)));
         end
         key_clear();
      end

      // Free-running random strobes, coincident ones included.
      for (int i = 0; i < 1500; i++) begin
         bit s, c, cl, n;
         s = ($urandom_range(0, 99) < 8);
         c = ($urandom_range(0, 99) < 7);
         cl = ($urandom_range(0, 99) < 3);
         n = ($urandom_range(0, 99) < 40);
         cyc(s, c, cl, n, 4'($urandom_range(0, 11)));
      end

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
      $fatal(1);
   end

endmodule
